// File: rtl/fft_sample_loader.sv
// fft_sample_loader: collects complex samples into 8-slot frames and holds each frame stable for an 8-point FFT core
//
// Ports:
//   clock        sole clock, all state updates on its rising edge
//   reset        synchronous active-high reset
//   in_valid     upstream sample valid
//   in_ready     loader can accept a sample this cycle
//   in_re/in_im  signed 16-bit sample, real / imaginary
//   in_last      final sample of a short frame (remaining slots zero-padded)
//   frame_re/im  eight 16-bit slots, slot k at bits [127-16k -: 16] (xin1..xin8 / yin1..yin8)
//   frame_valid  frame_re/frame_im hold a launched frame
//   frame_start  one-cycle pulse on the first cycle of each launched frame
//   frame_done   one-cycle pulse on the last hold cycle of each frame
//   frame_count  frames launched since reset, modulo 256
module fft_sample_loader #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_re,
    input  logic [15:0]  in_im,
    input  logic         in_last,
    output logic [127:0] frame_re,
    output logic [127:0] frame_im,
    output logic         frame_valid,
    output logic         frame_start,
    output logic         frame_done,
    output logic [7:0]   frame_count
);

    localparam logic [7:0] HC_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state_q, state_d;
    logic [7:0]   hc_q, hc_d;
    logic [3:0]   fill_q, fill_d;
    logic [15:0]  slot_re_q [8];
    logic [15:0]  slot_re_d [8];
    logic [15:0]  slot_im_q [8];
    logic [15:0]  slot_im_d [8];
    logic [127:0] frame_re_q, frame_re_d;
    logic [127:0] frame_im_q, frame_im_d;
    logic         frame_start_q, frame_start_d;
    logic [7:0]   frame_count_q, frame_count_d;
    logic         full, accept, hold_last, launch;

    // A full buffer is what blocks input, so accept and launch never share an edge.
    always_comb begin
        full      = fill_q == 4'd8;
        in_ready  = !reset && !full;
        accept    = in_valid && in_ready;
        hold_last = state_q == HOLD && hc_q == HC_LAST;
        launch    = full && (state_q == IDLE || hold_last);
    end

    // Collect buffer: in_last on slot i<7 zero-fills the tail and marks the buffer full.
    always_comb begin
        fill_d    = fill_q;
        slot_re_d = slot_re_q;
        slot_im_d = slot_im_q;
        if (launch) begin
            fill_d = 4'd0;
        end else if (accept) begin
            fill_d = in_last ? 4'd8 : fill_q + 4'd1;
            for (int i = 0; i < 8; i++) begin
                if (4'(i) == fill_q) begin
                    slot_re_d[i] = in_re;
                    slot_im_d[i] = in_im;
                end else if (in_last && 4'(i) > fill_q) begin
                    slot_re_d[i] = 16'h0000;
                    slot_im_d[i] = 16'h0000;
                end
            end
        end
    end

    // Output register pair changes only on a launch edge.
    always_comb begin
        frame_re_d    = frame_re_q;
        frame_im_d    = frame_im_q;
        frame_start_d = launch;
        frame_count_d = launch ? frame_count_q + 8'd1 : frame_count_q;
        if (launch) begin
            for (int i = 0; i < 8; i++) begin
                frame_re_d[127-16*i -: 16] = slot_re_q[i];
                frame_im_d[127-16*i -: 16] = slot_im_q[i];
            end
        end
    end

    // Output FSM: next state
    always_comb begin
        state_d = launch ? HOLD : hold_last ? IDLE : state_q;
        hc_d    = (launch || state_q == IDLE) ? 8'd0 : hc_q + 8'd1;
    end

    // Output FSM: state register plus datapath flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            hc_q          <= 8'd0;
            fill_q        <= 4'd0;
            frame_re_q    <= '0;
            frame_im_q    <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                slot_re_q[i] <= 16'h0000;
                slot_im_q[i] <= 16'h0000;
            end
        end else begin
            state_q       <= state_d;
            hc_q          <= hc_d;
            fill_q        <= fill_d;
            frame_re_q    <= frame_re_d;
            frame_im_q    <= frame_im_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            slot_re_q     <= slot_re_d;
            slot_im_q     <= slot_im_d;
        end
    end

    // Output FSM: outputs
    always_comb begin
        frame_valid = state_q == HOLD;
        frame_done  = hold_last;
        frame_start = frame_start_q;
        frame_count = frame_count_q;
        frame_re    = frame_re_q;
        frame_im    = frame_im_q;
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader: directed checks of fft_sample_loader with HOLD_CYCLES of 8, 20 and 1
module tb_fft_sample_loader;

    logic         clock = 1'b0;
    logic         rst;
    logic [2:0]   vld, last, rdy, fv, fs, fd;
    logic [15:0]  re [3];
    logic [15:0]  im [3];
    logic [127:0] fre [3];
    logic [127:0] fim [3];
    logic [7:0]   fc [3];
    int           n_cmp = 0;
    int           n_err = 0;
    int           fs_cnt = 0;
    int           fd_cnt = 0;
    logic [127:0] fq [$];

    always #5 clock = ~clock;

    fft_sample_loader #(.HOLD_CYCLES(8)) u_h8 (
        .clock(clock), .reset(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_re(re[0]), .in_im(im[0]), .in_last(last[0]),
        .frame_re(fre[0]), .frame_im(fim[0]), .frame_valid(fv[0]),
        .frame_start(fs[0]), .frame_done(fd[0]), .frame_count(fc[0])
    );

    fft_sample_loader #(.HOLD_CYCLES(20)) u_h20 (
        .clock(clock), .reset(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_re(re[1]), .in_im(im[1]), .in_last(last[1]),
        .frame_re(fre[1]), .frame_im(fim[1]), .frame_valid(fv[1]),
        .frame_start(fs[1]), .frame_done(fd[1]), .frame_count(fc[1])
    );

    fft_sample_loader #(.HOLD_CYCLES(1)) u_h1 (
        .clock(clock), .reset(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_re(re[2]), .in_im(im[2]), .in_last(last[2]),
        .frame_re(fre[2]), .frame_im(fim[2]), .frame_valid(fv[2]),
        .frame_start(fs[2]), .frame_done(fd[2]), .frame_count(fc[2])
    );

    always @(negedge clock) begin
        if (!rst) begin
            if (fs[2]) begin
                fs_cnt++;
                fq.push_back(fre[2]);
            end
            if (fd[2]) fd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [15:0] base, input logic [15:0] step, input int n);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[127-16*k -: 16] = k < n ? base + step * 16'(k) : 16'h0000;
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int d, input logic [15:0] r, input logic [15:0] i, input logic l);
        int n;
        logic acc;
        vld[d]  = 1'b1;
        re[d]   = r;
        im[d]   = i;
        last[d] = l;
        n = 0;
        do begin
            acc = rdy[d];
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 0, 1);
        vld[d]  = 1'b0;
        last[d] = 1'b0;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1;
        vld = '0;
        last = '0;
        for (int d = 0; d < 3; d++) begin
            re[d] = '0;
            im[d] = '0;
        end
        repeat (2) tick();
        check("rdy_in_reset", rdy, 3'b000);
        rst = 1'b0;
        #1;
        check("reset_ctl", {fv, fs, fd, rdy}, {9'b0, 3'b111});
        check("reset_cnt", {fc[0], fc[1], fc[2]}, 24'd0);
        check("reset_re", fre[0], 128'd0);
        check("reset_im", fim[0], 128'd0);

        // single full frame, HOLD_CYCLES=8
        for (int k = 0; k < 8; k++) send(0, 16'(k + 1), 16'(-(k + 1)), 1'b0);
        check("t1_prelaunch", {fv[0], rdy[0]}, 2'b00);
        tick();
        check("t1_re", fre[0], pack(16'd1, 16'd1, 8));
        check("t1_im", fim[0], pack(16'hFFFF, 16'hFFFF, 8));
        check("t1_count", fc[0], 8'd1);
        for (int c = 0; c < 8; c++) begin
            check("t1_hold", {fv[0], fs[0], fd[0]}, {1'b1, c == 0, c == 7});
            tick();
        end
        check("t1_idle", {fv[0], fs[0], fd[0]}, 3'b000);

        // short frame with in_last on the third sample
        for (int k = 0; k < 3; k++) send(0, 16'(k + 5), 16'(16'h1005 + k), k == 2);
        check("t2_prelaunch", {fv[0], rdy[0]}, 2'b00);
        tick();
        check("t2_start", {fv[0], fs[0]}, 2'b11);
        check("t2_re", fre[0], pack(16'd5, 16'd1, 3));
        check("t2_im", fim[0], pack(16'h1005, 16'd1, 3));
        check("t2_count", fc[0], 8'd2);
        repeat (8) tick();
        check("t2_idle", {fv[0], rdy[0]}, 2'b01);
        check("t2_retain", fre[0], pack(16'd5, 16'd1, 3));

        // backpressure, HOLD_CYCLES=20
        for (int k = 0; k < 16; k++) send(1, 16'(k + 1), 16'(100 + k), 1'b0);
        check("t3_full", {fv[1], rdy[1], fc[1]}, {2'b10, 8'd1});
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("t3_bp", {fv[1], rdy[1], fs[1], fd[1]}, {1'b1, n == 12, n == 12, n == 11});
        end
        check("t3_re", fre[1], pack(16'd9, 16'd1, 8));
        check("t3_im", fim[1], pack(16'd108, 16'd1, 8));
        check("t3_count", fc[1], 8'd2);

        // HOLD_CYCLES=1, continuous stream of three frames
        for (int k = 0; k < 24; k++) send(2, 16'(200 + k), 16'(k), 1'b0);
        repeat (3) tick();
        check("t4_starts", fs_cnt, 3);
        check("t4_dones", fd_cnt, 3);
        for (int f = 0; f < 3; f++)
            check("t4_frame", f < fq.size() ? fq[f] : 'x, pack(16'(200 + 8 * f), 16'd1, 8));
        check("t4_count", fc[2], 8'd3);

        // reset after 5 accepts, then in the 3rd hold cycle
        for (int k = 0; k < 5; k++) send(0, 16'(16'h40 + k), 16'h0, 1'b0);
        pulse_reset();
        check("t5a_ctl", {fv[0], fs[0], fd[0], rdy[0], fc[0]}, {4'b0001, 8'd0});
        check("t5a_re", fre[0], 128'd0);
        for (int k = 0; k < 8; k++) send(0, 16'(16'h50 + k), 16'h0, 1'b0);
        tick();
        check("t5b_re", fre[0], pack(16'h50, 16'd1, 8));
        check("t5b_count", fc[0], 8'd1);
        repeat (2) tick();
        pulse_reset();
        check("t5c_ctl", {fv[0], fs[0], fd[0], fc[0]}, 11'd0);
        check("t5c_re", fre[0], 128'd0);
        check("t5c_im", fim[0], 128'd0);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            seen = seen | fv[0] | fd[0];
            tick();
        end
        check("t5c_quiet", seen, 1'b0);
        for (int k = 0; k < 8; k++) send(0, 16'(16'h60 + k), 16'(16'h70 + k), 1'b0);
        tick();
        check("t5d_re", fre[0], pack(16'h60, 16'd1, 8));
        check("t5d_im", fim[0], pack(16'h70, 16'd1, 8));
        check("t5d_count", fc[0], 8'd1);

        // frame_count wrap after 256 frames
        pulse_reset();
        for (int f = 0; f < 255; f++)
            for (int k = 0; k < 8; k++) send(2, 16'(f * 8 + k), 16'h0, 1'b0);
        repeat (2) tick();
        check("t6_count255", fc[2], 8'd255);
        for (int k = 0; k < 8; k++) send(2, 16'(2040 + k), 16'h0, 1'b0);
        repeat (2) tick();
        check("t6_wrap", fc[2], 8'd0);
        check("t6_re", fre[2], pack(16'd2040, 16'd1, 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
